// File: rtl/hazard_tracker.sv
// Stall and forwarding control for the 5-stage MIPS pipeline, driven by a shadow E/M/W slot pipeline.
// Optional macro HAZARD_TRACKER_STALL_CNT_EN adds a 32-bit stall-cycle counter output.
module hazard_tracker #(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          h_d1,
    input  logic          h_d2,
    input  logic          h_e1,
    input  logic          h_e2,
    input  logic          h_mu,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic          fwd_m_rt
`ifdef HAZARD_TRACKER_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    logic [AW-1:0] e_wa_q, e_rs_q, e_rt_q, e_wa_d, e_rs_d, e_rt_d;
    logic [TW-1:0] e_tnew_q, e_tnew_d;
    logic          e_rsu_q, e_rtu_q, e_rsu_d, e_rtu_d;
    logic [AW-1:0] m_wa_q, m_rs_q, m_rt_q;
    logic [TW-1:0] m_tnew_q, m_tnew_d;
    logic          m_rsu_q, m_rtu_q;
    logic [AW-1:0] w_wa_q, w_rs_q, w_rt_q;
    logic [TW-1:0] w_tnew_q;

    logic [TW-1:0] rs_tuse, rt_tuse;
    logic          d_rsu, d_rtu, rs_hz, rt_hz;

    // Use flags and W-slot source fields are kept for visibility but feed no decision.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{m_rsu_q, m_rtu_q, w_tnew_q, w_rs_q, w_rt_q};

    assign d_rsu   = h_d1 | h_e1;
    assign d_rtu   = h_d2 | h_e2 | h_mu;
    assign rs_tuse = h_d1 ? TW'(0) : TW'(1);
    assign rt_tuse = h_d2 ? TW'(0) : (h_e2 ? TW'(1) : TW'(2));

    always_comb begin
        rs_hz = d_rsu && (d_rs != '0) &&
                ((d_rs == e_wa_q && e_tnew_q > rs_tuse) ||
                 (d_rs == m_wa_q && m_tnew_q > rs_tuse));
        rt_hz = d_rtu && (d_rt != '0) &&
                ((d_rt == e_wa_q && e_tnew_q > rt_tuse) ||
                 (d_rt == m_wa_q && m_tnew_q > rt_tuse));
        stall = rs_hz | rt_hz;
    end

    // D-stage selects: nearest ready producer wins; W reaches D through the GRF bypass.
    always_comb begin
        fwd_d_rs = 2'd0;
        if (d_rs != '0 && d_rs == e_wa_q && e_tnew_q == '0)      fwd_d_rs = 2'd1;
        else if (d_rs != '0 && d_rs == m_wa_q && m_tnew_q == '0) fwd_d_rs = 2'd2;
        fwd_d_rt = 2'd0;
        if (d_rt != '0 && d_rt == e_wa_q && e_tnew_q == '0)      fwd_d_rt = 2'd1;
        else if (d_rt != '0 && d_rt == m_wa_q && m_tnew_q == '0) fwd_d_rt = 2'd2;
    end

    always_comb begin
        fwd_e_rs = 2'd0;
        if (e_rs_q != '0 && e_rs_q == m_wa_q && m_tnew_q == '0) fwd_e_rs = 2'd1;
        else if (e_rs_q != '0 && e_rs_q == w_wa_q)              fwd_e_rs = 2'd2;
        fwd_e_rt = 2'd0;
        if (e_rt_q != '0 && e_rt_q == m_wa_q && m_tnew_q == '0) fwd_e_rt = 2'd1;
        else if (e_rt_q != '0 && e_rt_q == w_wa_q)              fwd_e_rt = 2'd2;
        fwd_m_rt = (w_wa_q != '0) && (m_rt_q == w_wa_q);
    end

    always_comb begin
        e_wa_d   = stall ? '0 : d_wa;
        e_tnew_d = stall ? '0 : d_tnew;
        e_rs_d   = stall ? '0 : d_rs;
        e_rt_d   = stall ? '0 : d_rt;
        e_rsu_d  = stall ? 1'b0 : d_rsu;
        e_rtu_d  = stall ? 1'b0 : d_rtu;
        m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_wa_q <= '0; e_tnew_q <= '0; e_rs_q <= '0; e_rt_q <= '0;
            e_rsu_q <= 1'b0; e_rtu_q <= 1'b0;
            m_wa_q <= '0; m_tnew_q <= '0; m_rs_q <= '0; m_rt_q <= '0;
            m_rsu_q <= 1'b0; m_rtu_q <= 1'b0;
            w_wa_q <= '0; w_tnew_q <= '0; w_rs_q <= '0; w_rt_q <= '0;
        end else begin
            e_wa_q <= e_wa_d; e_tnew_q <= e_tnew_d; e_rs_q <= e_rs_d; e_rt_q <= e_rt_d;
            e_rsu_q <= e_rsu_d; e_rtu_q <= e_rtu_d;
            m_wa_q <= e_wa_q; m_tnew_q <= m_tnew_d; m_rs_q <= e_rs_q; m_rt_q <= e_rt_q;
            m_rsu_q <= e_rsu_q; m_rtu_q <= e_rtu_q;
            w_wa_q <= m_wa_q; w_tnew_q <= '0; w_rs_q <= m_rs_q; w_rt_q <= m_rt_q;
        end
    end

`ifdef HAZARD_TRACKER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     stall_cnt_q <= '0;
        else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector bench for hazard_tracker: MIPS instruction pairs with hand-computed stall/select values.
module tb_hazard_tracker;

    logic       clk, rst_n;
    logic [4:0] d_rs, d_rt, d_wa;
    logic       h_d1, h_d2, h_e1, h_e2, h_mu;
    logic [1:0] d_tnew;
    logic       stall, fwd_m_rt;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
`ifdef HAZARD_TRACKER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int nchk = 0;
    int nerr = 0;

    hazard_tracker #(.AW(5), .TW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt),
        .h_d1(h_d1), .h_d2(h_d2), .h_e1(h_e1), .h_e2(h_e2), .h_mu(h_mu),
        .d_wa(d_wa), .d_tnew(d_tnew),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .fwd_m_rt(fwd_m_rt)
`ifdef HAZARD_TRACKER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One D-stage instruction per call; applied mid-cycle and settled before checks.
    // fl = {h_d1, h_d2, h_e1, h_e2, h_mu}
    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] fl,
                       input logic [4:0] wa, input logic [1:0] tn);
        @(negedge clk);
        d_rs = rs; d_rt = rt; d_wa = wa; d_tnew = tn;
        {h_d1, h_d2, h_e1, h_e2, h_mu} = fl;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".stall"}, 32'(stall), 0);
        chk({tag, ".fdrs"}, 32'(fwd_d_rs), 0);
        chk({tag, ".fdrt"}, 32'(fwd_d_rt), 0);
        chk({tag, ".fers"}, 32'(fwd_e_rs), 0);
        chk({tag, ".fert"}, 32'(fwd_e_rt), 0);
        chk({tag, ".fmrt"}, 32'(fwd_m_rt), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        d_rs = '0; d_rt = '0; d_wa = '0; d_tnew = '0;
        {h_d1, h_d2, h_e1, h_e2, h_mu} = 5'b0;
        #12;
        chk_zero("rst_held");
`ifdef HAZARD_TRACKER_STALL_CNT_EN
        chk("rst_held.cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero("rst_rel");

        // Load-use on an E-use operand: one bubble, then W forwards into E.
        cyc(5'd29, 5'd0, 5'b00100, 5'd8, 2'd2);
        chk("lw.stall", 32'(stall), 0);
        cyc(5'd8, 5'd0, 5'b00110, 5'd10, 2'd1);
        chk("lu.stall1", 32'(stall), 1);
        cyc(5'd8, 5'd0, 5'b00110, 5'd10, 2'd1);
        chk("lu.stall2", 32'(stall), 0);
        cyc(5'd0, 5'd0, 5'b00000, 5'd0, 2'd0);
        chk("lu.fers", 32'(fwd_e_rs), 2);
        chk("lu.fert", 32'(fwd_e_rt), 0);

        // ALU result feeding a branch compare: one stall, then M forwards into D.
        cyc(5'd0, 5'd0, 5'b00100, 5'd9, 2'd1);
        chk("alu.stall", 32'(stall), 0);
        cyc(5'd9, 5'd0, 5'b11000, 5'd0, 2'd0);
        chk("ab.stall1", 32'(stall), 1);
        cyc(5'd9, 5'd0, 5'b11000, 5'd0, 2'd0);
        chk("ab.stall2", 32'(stall), 0);
        chk("ab.fdrs", 32'(fwd_d_rs), 2);
        chk("ab.fdrt", 32'(fwd_d_rt), 0);

        // jal then jr $31: link value is ready in E.
        cyc(5'd0, 5'd0, 5'b00000, 5'd31, 2'd0);
        chk("jal.stall", 32'(stall), 0);
        cyc(5'd31, 5'd0, 5'b10000, 5'd0, 2'd0);
        chk("jr.stall", 32'(stall), 0);
        chk("jr.fdrs", 32'(fwd_d_rs), 1);

        // ori then sw of that register: no stall, forwarded in E then in M.
        cyc(5'd0, 5'd0, 5'b00100, 5'd5, 2'd1);
        chk("ori.stall", 32'(stall), 0);
        cyc(5'd0, 5'd5, 5'b00101, 5'd0, 2'd0);
        chk("sw.stall", 32'(stall), 0);
        chk("sw.fdrt", 32'(fwd_d_rt), 0);
        cyc(5'd0, 5'd0, 5'b00000, 5'd0, 2'd0);
        chk("swE.fert", 32'(fwd_e_rt), 1);
        chk("swE.fers", 32'(fwd_e_rs), 0);
        cyc(5'd0, 5'd0, 5'b00000, 5'd0, 2'd0);
        chk("swM.fmrt", 32'(fwd_m_rt), 1);

        // Writes to $0 are inert.
        cyc(5'd0, 5'd0, 5'b00100, 5'd0, 2'd1);
        chk("z0.stall", 32'(stall), 0);
        cyc(5'd0, 5'd0, 5'b11000, 5'd0, 2'd0);
        chk_zero("z0.use");

        // Two producers of $7: the younger (E) wins in D, M wins over W in E.
        cyc(5'd0, 5'd0, 5'b00000, 5'd7, 2'd0);
        cyc(5'd0, 5'd0, 5'b00000, 5'd7, 2'd0);
        cyc(5'd7, 5'd0, 5'b10000, 5'd0, 2'd0);
        chk("dup.stall", 32'(stall), 0);
        chk("dup.fdrs", 32'(fwd_d_rs), 1);
        cyc(5'd0, 5'd0, 5'b00000, 5'd0, 2'd0);
        chk("dup.fers", 32'(fwd_e_rs), 1);

        // Load feeding a branch compare: two stalls, then GRF bypass from W.
        cyc(5'd29, 5'd0, 5'b00100, 5'd8, 2'd2);
        cyc(5'd8, 5'd0, 5'b10000, 5'd0, 2'd0);
        chk("lb.stall1", 32'(stall), 1);
        cyc(5'd8, 5'd0, 5'b10000, 5'd0, 2'd0);
        chk("lb.stall2", 32'(stall), 1);
        cyc(5'd8, 5'd0, 5'b10000, 5'd0, 2'd0);
        chk("lb.stall3", 32'(stall), 0);
        chk("lb.fdrs", 32'(fwd_d_rs), 0);
`ifdef HAZARD_TRACKER_STALL_CNT_EN
        chk("cnt", stall_cnt, 4);
`endif

        // Reset asserted in the middle of a load/branch stall.
        cyc(5'd0, 5'd0, 5'b00000, 5'd0, 2'd0);
        cyc(5'd29, 5'd0, 5'b00100, 5'd8, 2'd2);
        cyc(5'd8, 5'd0, 5'b10000, 5'd0, 2'd0);
        chk("mr.pre", 32'(stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mr");
`ifdef HAZARD_TRACKER_STALL_CNT_EN
        chk("mr.cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        #1;
        chk("mr.held", 32'(stall), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Sits beside the D-stage decode controller in the 5-stage MIPS pipeline. Consumes the controller's per-operand Tuse flags (D-use / E-use / M-use) and its destination address / result-timing class.
- Keeps its own shadow pipeline (E, M, W slots) of destination address, Tnew and source addresses.
- Each cycle it produces the stall decision and every forwarding-mux select for the D, E and M stages.

Parameters:
- AW, 5, register address width.
- TW, 2, width of the Tnew field.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- d_rs  in  AW  rs field of the instruction in D.
- d_rt  in  AW  rt field of the instruction in D.
- h_d1  in  1  rs used in D (Tuse=0).
- h_d2  in  1  rt used in D (Tuse=0).
- h_e1  in  1  rs used in E (Tuse=1).
- h_e2  in  1  rt used in E (Tuse=1).
- h_mu  in  1  rt used in M (Tuse=2).
- d_wa  in  AW  destination address of D instruction; 0 = no write.
- d_tnew  in  TW  Tnew on entering E: 0 = link value (PC+8), 1 = ALU result, 2 = load.
- stall  out  1  freeze PC and F/D; insert bubble into D/E.
- fwd_d_rs  out  2  D rs select: 0 GRF, 1 E, 2 M.
- fwd_d_rt  out  2  D rt select, same encoding.
- fwd_e_rs  out  2  E rs select: 0 pipeline reg, 1 M, 2 W.
- fwd_e_rt  out  2  E rt select, same encoding.
- fwd_m_rt  out  1  M rt select: 0 pipeline reg, 1 W.

Behaviour:
- Slot state: E/M/W each hold wa, tnew, rs, rt. E and M also hold use flags (rs_used, rt_used). A slot with wa==0 is inert: it never matches and never stalls.
- Reset: asynchronous on rst_n low. All slot fields clear to 0. All outputs read 0 while reset is held and in the first cycle after release.
- Advance on every posedge clk:
  - W <= M, with tnew forced to 0.
  - M <= E, with tnew = sat(E.tnew-1), floored at 0.
  - E <= D fields when stall==0. When stall==1, E <= bubble (all fields 0).
- Stall is combinational from the D inputs and the E/M slots. No state machine; all history lives in the slots.
  - Per D operand r in {rs, rt}, tuse = 0 if h_d*; else 1 if h_e*; else 2 if h_mu (rt only); else the operand is unused.
  - stall = OR over used operands of:
    - (r!=0 and r==E.wa and E.tnew>tuse), or
    - (r!=0 and r==M.wa and M.tnew>tuse).
  - Operand priority is not applied: any single hazard stalls.
- D forwarding:
  - Select E if r==E.wa, r!=0 and E.tnew==0.
  - Else select M if r==M.wa, r!=0 and M.tnew==0.
  - Else select GRF; the GRF provides W-to-D internal bypass.
  - Nearest stage wins.
- E forwarding, using the E slot's rs/rt:
  - Select M if matched and M.tnew==0.
  - Else select W if matched.
  - Else 0.
  - Address 0 never forwards.
- M forwarding: fwd_m_rt = 1 when M.rt==W.wa and W.wa!=0.
- Selects are valid whenever stall==0. When stall==1, D selects are don't-care but must still be deterministic.
- Stall sequencing:
  - Load-use (lw then immediate E-use) gives exactly 1 stall cycle.
  - Load then D-use (beq/jr) gives 2 stall cycles.
  - ALU then D-use gives 1 stall cycle.
- Simultaneous write targets: if E and M target the same register, E wins (younger).
- Reset asserted mid-stall: stall drops with reset. No pending bubble is retained.

Optional Feature:
- HAZARD_TRACKER_STALL_CNT_EN.
- Defined: adds output port stall_cnt, 32 bits.
  - Counts cycles with stall==1.
  - Cleared by rst_n; wraps modulo 2^32 with no saturation.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
1. lw $8 (d_wa=8, d_tnew=2), next cycle addu using rs=8 (h_e1=1) -> stall=1 for 1 cycle. After the bubble, fwd_e_rs=2 (W) when addu is in E.
2. addu $9 (tnew=1), then beq rs=9, rt=0 (h_d1=h_d2=1) -> stall=1 for 1 cycle. Next cycle fwd_d_rs=2 (M), fwd_d_rt=0.
3. jal (d_wa=31, tnew=0), then jr rs=31 (h_d1=1) -> stall=0, fwd_d_rs=1 (E).
4. ori $5, then sw rt=5, rs=0 (h_mu=1, h_e1=1) -> no stall. When sw is in E: fwd_e_rt=1 (M). When sw is in M: fwd_m_rt=1.
5. Instruction writing $0 (d_wa=0), followed by a consumer of rs=0 at any Tuse -> stall=0 and all selects 0.
6. Assert rst_n=0 asynchronously while stall==1 (lw/beq pair) -> stall and all selects 0 immediately. With HAZARD_TRACKER_STALL_CNT_EN, stall_cnt=0.
